// File: rtl/shared_pkg.sv
// Shared types and constants for the FIFO read-side drain stage.
// Optional framing in fifo_stream_reader is enabled by defining FIFO_READER_LAST_EN.
package shared_pkg;

  // Entries in the read-side skid queue.
  localparam int unsigned READER_BUF_DEPTH = 3;
  // Pointer width for the skid queue.
  localparam int unsigned READER_PTR_W = 2;
  // Default FIFO word width shared with the synchronous FIFO.
  localparam int unsigned SHARED_FIFO_WIDTH = 16;

  typedef logic [SHARED_FIFO_WIDTH-1:0] fifo_word_t;

  // Circular pointer increment; wraps from the last entry back to 0.
  function automatic logic [READER_PTR_W-1:0] reader_ptr_inc(input logic [READER_PTR_W-1:0] ptr);
    return (ptr == READER_PTR_W'(READER_BUF_DEPTH - 1)) ? '0 : ptr + READER_PTR_W'(1);
  endfunction

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// reader_buf: 3-entry circular queue with push/pop and occupancy count.
// Holds no flow control; the caller guarantees no push when full and no pop when empty.
module reader_buf
  import shared_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rd_data_c,
  output logic [1:0]       o_occ
);

  logic [WIDTH-1:0]        r_mem [READER_BUF_DEPTH];
  logic [READER_PTR_W-1:0] r_wr_ptr;
  logic [READER_PTR_W-1:0] r_rd_ptr;
  logic [1:0]              r_occ;

  // Storage write; cleared on reset so the head reads 0 while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < READER_BUF_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop keeps occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= reader_ptr_inc(r_wr_ptr);
      end
      if (i_pop) begin
        r_rd_ptr <= reader_ptr_inc(r_rd_ptr);
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_rd_data_c = r_mem[r_rd_ptr];
  assign o_occ       = r_occ;

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops words from a synchronous FIFO and presents them as a
// valid/ready stream, absorbing FIFO read latency and downstream backpressure.
// Define FIFO_READER_LAST_EN to compile in packet framing (m_last every PKT_LEN beats).
module fifo_stream_reader
  import shared_pkg::*;
#(
  parameter int unsigned FIFO_WIDTH = 16,
  parameter int unsigned PKT_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  underflow_err
);

  localparam int unsigned CREDIT_W = 3;

  logic                  r_inflight;
  logic                  r_underflow_err;
  logic [1:0]            w_occ;
  logic                  w_credit;
  logic                  w_pop;
  logic [FIFO_WIDTH-1:0] w_head;

  // Reject packet lengths outside the supported range at elaboration.
  if ((PKT_LEN < 2) || (PKT_LEN > 256)) begin : g_bad_pkt_len
    $error("fifo_stream_reader: PKT_LEN must be in 2..256");
  end

  // Issue only when buffered plus in-flight words leave room; m_ready never feeds this.
  assign w_credit   = (CREDIT_W'(w_occ) + CREDIT_W'(r_inflight)) < CREDIT_W'(READER_BUF_DEPTH);
  assign fifo_rd_en = rst_n && !fifo_empty && w_credit;

  assign m_valid = (w_occ != 2'd0);
  assign w_pop   = m_valid && m_ready;
  assign m_data  = w_head;

  // FIFO read data arrives one cycle after the pop request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= fifo_rd_en;
    end
  end

  // Sticky protocol-violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_underflow_err <= 1'b0;
    end else if (fifo_underflow) begin
      r_underflow_err <= 1'b1;
    end
  end

  assign underflow_err = r_underflow_err;

  reader_buf #(
    .WIDTH (FIFO_WIDTH)
  ) u_buf (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (r_inflight),
    .i_push_data (fifo_data_out),
    .i_pop       (w_pop),
    .o_rd_data_c (w_head),
    .o_occ       (w_occ)
  );

`ifdef FIFO_READER_LAST_EN
  localparam int unsigned BEAT_W = $clog2(PKT_LEN);

  logic [BEAT_W-1:0] r_beat;

  // Beat position within the packet; advances only on a completed transfer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= (r_beat == BEAT_W'(PKT_LEN - 1)) ? '0 : r_beat + BEAT_W'(1);
    end
  end

  assign m_last = m_valid && (r_beat == BEAT_W'(PKT_LEN - 1));
`else
  assign m_last = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader with a behavioural FIFO front end.
module tb_fifo_stream_reader;
  import shared_pkg::*;

  localparam int unsigned W   = 16;
  localparam int unsigned PKT = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data_out = '0;
  logic         fifo_underflow = 1'b0;
  logic         fifo_rd_en;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [W-1:0] m_data;
  logic         m_last;
  logic         underflow_err;

  int total = 0;
  int bad   = 0;

  fifo_word_t fq[$];

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .FIFO_WIDTH (W),
    .PKT_LEN    (PKT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .m_last         (m_last),
    .underflow_err  (underflow_err)
  );

  // Behavioural FIFO: data valid the cycle after a read, empty flag updated on the edge.
  always @(posedge clk) begin : fifo_model
    logic pend;
    pend = fifo_rd_en;
    #1;
    if (pend && (fq.size() > 0)) fifo_data_out = fq.pop_front();
    fifo_empty = (fq.size() == 0);
  end

  // Credit accounting must never allow a full queue with a word still in flight.
  always @(negedge clk) begin
    total++;
    if (dut.w_occ == 2'd3 && dut.r_inflight) begin
      $display("FAIL no_overflow: occ=3 with inflight=1 at %0t", $time);
      bad++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    fq.delete();
    m_ready = 1'b0;
    fifo_underflow = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    fq.delete();
    fq.push_back(16'h1234);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (fifo_rd_en !== 1'b0) begin
        $display("FAIL reset_rd_en cyc%0d: got %b want 0 (fifo_empty=%b)", i, fifo_rd_en, fifo_empty); bad++;
      end
      total++;
      if (m_valid !== 1'b0) begin $display("FAIL reset_m_valid: got %b want 0", m_valid); bad++; end
      total++;
      if (m_data !== 16'h0000) begin $display("FAIL reset_m_data: got %h want 0000", m_data); bad++; end
      total++;
      if (m_last !== 1'b0) begin $display("FAIL reset_m_last: got %b want 0", m_last); bad++; end
      total++;
      if (underflow_err !== 1'b0) begin $display("FAIL reset_err: got %b want 0", underflow_err); bad++; end
    end
    fq.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    m_ready = 1'b1;
    fq.push_back(16'hA5A5);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      total++;
      if (fifo_rd_en !== (k == 1)) begin
        $display("FAIL single_rd_en k=%0d: got %b want %b", k, fifo_rd_en, (k == 1)); bad++;
      end
      total++;
      if (m_valid !== (k == 3)) begin
        $display("FAIL single_m_valid k=%0d: got %b want %b", k, m_valid, (k == 3)); bad++;
      end
      if (k == 3) begin
        total++;
        if (m_data !== 16'hA5A5) begin $display("FAIL single_m_data: got %h want a5a5", m_data); bad++; end
      end
    end
  endtask

  task automatic test_stream();
    int n = 0;
    int cyc = 0;
    bit started = 1'b0;
    bit gap = 1'b0;
    do_reset();
    m_ready = 1'b1;
    for (int i = 1; i <= 8; i++) fq.push_back(16'(i));
    while (n < 8 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        started = 1'b1;
        total++;
        if (m_data !== 16'(n + 1)) begin
          $display("FAIL stream_data beat%0d: got %h want %h", n, m_data, 16'(n + 1)); bad++;
        end
        n++;
      end else if (started) begin
        gap = 1'b1;
      end
    end
    total++;
    if (n != 8) begin $display("FAIL stream_count: got %0d want 8", n); bad++; end
    total++;
    if (gap) begin $display("FAIL stream_gap: got gap=1 want 0"); bad++; end
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    int n = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    logic [W-1:0] held = '0;
    do_reset();
    m_ready = 1'b0;
    for (int i = 0; i < 8; i++) fq.push_back(16'(16'h0011 + i));
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (fifo_rd_en) pulses++;
    end
    total++;
    if (pulses != 3) begin $display("FAIL bp_pulses: got %0d want 3", pulses); bad++; end
    total++;
    if (fifo_rd_en !== 1'b0) begin $display("FAIL bp_rd_idle: got %b want 0", fifo_rd_en); bad++; end
    total++;
    if (m_valid !== 1'b1 || m_data !== 16'h0011) begin
      $display("FAIL bp_head: got valid=%b data=%h want valid=1 data=0011", m_valid, m_data); bad++;
    end
    while (n < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (stalled) begin
        total++;
        if (m_data !== held) begin $display("FAIL bp_hold: got %h want %h", m_data, held); bad++; end
      end
      if (m_valid) begin
        m_ready = (cyc % 3 != 0);
        if (m_ready) begin
          total++;
          if (m_data !== 16'(16'h0011 + n)) begin
            $display("FAIL bp_data beat%0d: got %h want %h", n, m_data, 16'(16'h0011 + n)); bad++;
          end
          n++;
          stalled = 1'b0;
        end else begin
          held = m_data;
          stalled = 1'b1;
        end
      end else begin
        stalled = 1'b0;
      end
    end
    total++;
    if (n != 8) begin $display("FAIL bp_count: got %0d want 8", n); bad++; end
  endtask

  task automatic test_framing();
    int n = 0;
    int stall = 0;
    int cyc = 0;
    logic exp_last;
    do_reset();
    m_ready = 1'b1;
    for (int i = 0; i < 8; i++) fq.push_back(16'(16'h0021 + i));
    while (n < 8 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (m_valid) begin
        if (n == 2 && stall < 2) begin
          m_ready = 1'b0;
          stall++;
          total++;
          if (m_last !== 1'b0) begin $display("FAIL frame_stall_last: got %b want 0", m_last); bad++; end
        end else begin
          m_ready = 1'b1;
`ifdef FIFO_READER_LAST_EN
          exp_last = (n == 3) || (n == 7);
`else
          exp_last = 1'b0;
`endif
          total++;
          if (m_last !== exp_last) begin
            $display("FAIL frame_last beat%0d: got %b want %b", n + 1, m_last, exp_last); bad++;
          end
          total++;
          if (m_data !== 16'(16'h0021 + n)) begin
            $display("FAIL frame_data beat%0d: got %h want %h", n + 1, m_data, 16'(16'h0021 + n)); bad++;
          end
          n++;
        end
      end
    end
    total++;
    if (n != 8) begin $display("FAIL frame_count: got %0d want 8", n); bad++; end
  endtask

  task automatic test_underflow();
    do_reset();
    fifo_underflow = 1'b1;
    total++;
    if (underflow_err !== 1'b0) begin $display("FAIL err_pre: got %b want 0", underflow_err); bad++; end
    @(negedge clk);
    fifo_underflow = 1'b0;
    total++;
    if (underflow_err !== 1'b1) begin $display("FAIL err_set: got %b want 1", underflow_err); bad++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (underflow_err !== 1'b1) begin $display("FAIL err_sticky cyc%0d: got %b want 1", i, underflow_err); bad++; end
    end
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (underflow_err !== 1'b0) begin $display("FAIL err_clear: got %b want 0", underflow_err); bad++; end
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_framing();
    test_underflow();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain stage placed directly downstream of the synchronous FIFO. It pops words from the FIFO and presents them as a valid/ready stream. A small internal buffer absorbs the FIFO's one-cycle read latency and downstream backpressure. The FIFO never sees a read while empty, and `m_ready` has no combinational path to `fifo_rd_en`.

## Interface

Parameters:
- `FIFO_WIDTH`, 16 — word width; must match the FIFO.
- `PKT_LEN`, 4 — beats per packet; used only when framing is compiled in. Legal range 2..256.

Ports:
- `clk` — in, 1 — clock; all logic on posedge.
- `rst_n` — in, 1 — synchronous, active-low reset.
- `fifo_empty` — in, 1 — FIFO empty flag.
- `fifo_data_out` — in, `FIFO_WIDTH` — FIFO read data; valid in the cycle after an accepted `fifo_rd_en`.
- `fifo_underflow` — in, 1 — FIFO underflow flag.
- `fifo_rd_en` — out, 1 — pop request to the FIFO.
- `m_valid` — out, 1 — output word valid.
- `m_ready` — in, 1 — downstream accept.
- `m_data` — out, `FIFO_WIDTH` — output word.
- `m_last` — out, 1 — last beat of a packet; tied 0 when framing is compiled out.
- `underflow_err` — out, 1 — sticky protocol-violation flag.

## Operation

- Internal queue: `READER_BUF_DEPTH` = 3 entries, circular, with 2-bit `wr_ptr`/`rd_ptr` wrapping 2→0. Occupancy counter `occ` ranges 0..3.
- `inflight` register: set when `fifo_rd_en` is asserted; data is captured into the queue on the next edge.
- Issue rule: `fifo_rd_en = !fifo_empty && (occ + inflight < 3)`. It uses registered state and `fifo_empty` only.
- Pop rule: `m_valid = (occ != 0)`. `m_data` is the entry at `rd_ptr`. A beat transfers when `m_valid && m_ready`.
- Capture and pop in the same cycle: `occ` is unchanged and both pointers advance.
- Credit accounting guarantees the queue never overflows. `occ == 3` with `inflight == 1` is unreachable; the bench asserts this.
- `fifo_empty` is sampled as given. The FIFO updates it on the edge after a pop, so back-to-back reads from a count-1 FIFO cannot occur.
- `underflow_err`: set on the cycle after `fifo_underflow` is high and held until reset. This event is illegal when the FIFO is driven only by this block.
- `m_data` must hold stable while `m_valid && !m_ready`.

## Timing

- Reset values: `fifo_rd_en` 0, `m_valid` 0, `m_data` 0, `m_last` 0, `underflow_err` 0, `occ` 0, `inflight` 0, pointers 0, beat counter 0.
- While `rst_n` is low, `fifo_rd_en` is forced 0 regardless of `fifo_empty`.
- Latency: `fifo_rd_en` high in cycle t → `fifo_data_out` valid in t+1 → `m_valid` high in t+2.
- Throughput: 1 word/cycle sustained with `m_ready` held high and the FIFO non-empty.
- Reset mid-operation: in-flight and buffered words are discarded. The FIFO shares `rst_n`, so no data is double-counted. The first read after release happens no earlier than the cycle after `rst_n` rises.
- Simultaneous capture, pop and new issue in one cycle is legal.

## Configuration

- Macro: `FIFO_READER_LAST_EN`.
- Defined:
  - A `$clog2(PKT_LEN)`-bit beat counter advances on each transfer and wraps to 0 after `PKT_LEN-1`.
  - `m_last = m_valid && (beat == PKT_LEN-1)`.
  - The counter does not advance while stalled.
- Undefined: the counter is absent and `m_last` is constant 0. All other behaviour is identical.

## Structure

- `shared_pkg` adds:
  - `READER_BUF_DEPTH` = 3
  - `typedef logic [FIFO_WIDTH-1:0] fifo_word_t`
- The queue storage, pointers and `occ` live in one sub-module, `reader_buf`: push/pop interface, no flow-control logic.
- The top level holds the issue logic, the `inflight` register, the beat counter and the error flag.

## Test plan

- Reset: hold `rst_n` low 3 cycles with `fifo_empty` = 0 → `fifo_rd_en` 0 throughout; all outputs 0.
- Single word: FIFO holds 0xA5A5, `m_ready` = 1 → one `fifo_rd_en` pulse at cycle t; `m_valid` with `m_data` = 0xA5A5 only at t+2.
- Stream: 8 words 0x0001..0x0008, `m_ready` = 1 → `m_valid` high for 8 consecutive cycles, data in order, no gaps.
- Backpressure: 8 words, `m_ready` = 0 → exactly 3 `fifo_rd_en` pulses, then 0. Releasing `m_ready` delivers all 8 words in order with `m_data` stable while stalled.
- Framing (`FIFO_READER_LAST_EN`, `PKT_LEN` = 4): 8 beats with `m_ready` dropped on beat 3 for 2 cycles → `m_last` only on beats 4 and 8.
- Error: inject a one-cycle `fifo_underflow` pulse → `underflow_err` = 1 from the next cycle until `rst_n` is asserted.
